trigger_period_meter: RTL

- Receive-side checker for the modulator's frequency trigger.
- Consumes the trigger pulse train and measures the interval between rising edges in clk_in cycles.
- Declares lock once consecutive periods match, and flags a missing trigger (timeout).
- Used in-system to confirm which division factor is active after a sw0 change, and as a self-check monitor in benches.

---
 rtl/trigger_period_meter_pkg.sv | 18 +
 rtl/trigger_period_meter_rising_edge_detect.sv | 18 +
 rtl/trigger_period_meter.sv | 102 ++++++++++
 3 files changed

// File: rtl/trigger_period_meter_pkg.sv
// Shared encodings and default sizing for the trigger period meter and trigger generator.
package trigger_period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  localparam int DEF_CNT_W    = 8;
  localparam int DEF_TIMEOUT  = 255;
  localparam int DEF_LOCK_CNT = 2;
  // Division-factor width of the trigger generator matches the period counter.
  localparam int DIV_W        = DEF_CNT_W;
  localparam int MATCH_W      = 4;

endpackage

// File: rtl/trigger_period_meter_rising_edge_detect.sv
// Single-register rising edge detector; a level held high produces one edge.
module rising_edge_detect (
  input  logic clk_in,
  input  logic rst_in,
  input  logic sig_in,
  output logic edge_out
);

  logic sig_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) sig_q <= 1'b0;
    else        sig_q <= sig_in;
  end

  assign edge_out = sig_in & ~sig_q;

endmodule

// File: rtl/trigger_period_meter.sv
// Measures rising-edge to rising-edge period of the trigger, reports lock and missing-trigger timeout.
module trigger_period_meter
  import trigger_period_meter_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int LOCK_CNT = DEF_LOCK_CNT
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             freq_trig_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid_out,
  output logic             locked_out,
  output logic             timeout_out
);

  localparam logic [CNT_W-1:0]   TMO = CNT_W'(TIMEOUT);
  localparam logic [MATCH_W-1:0] LCK = MATCH_W'(LOCK_CNT);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt, period_nxt;
  logic [MATCH_W-1:0]   match, match_nxt, match_inc;
  logic                 trig_edge, same, timed_out, strobe_nxt, timeout_nxt;

  rising_edge_detect u_edge (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .sig_in   (freq_trig_in),
    .edge_out (trig_edge)
  );

  assign same      = (cnt == period_out);
  assign match_inc = same ? match + 1'b1 : MATCH_W'(1);
  // An edge landing exactly on cnt==TIMEOUT is a legal period, not a timeout.
  assign timed_out = (state != IDLE) && (cnt == TMO) && !trig_edge;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= IDLE;
      cnt              <= '0;
      match            <= '0;
      period_out       <= '0;
      period_valid_out <= 1'b0;
      locked_out       <= 1'b0;
      timeout_out      <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      match            <= match_nxt;
      period_out       <= period_nxt;
      period_valid_out <= strobe_nxt;
      locked_out       <= (state_nxt == LOCKED);
      timeout_out      <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (trig_edge) state_nxt = ARMED;
      ARMED:  if (trig_edge) state_nxt = (LOCK_CNT == 1) ? LOCKED : TRACK;
      TRACK:  if (trig_edge) state_nxt = (match_inc >= LCK) ? LOCKED : TRACK;
      LOCKED: if (trig_edge) state_nxt = same ? LOCKED : TRACK;
    endcase
    if (timed_out) state_nxt = IDLE;
  end

  always_comb begin
    cnt_nxt     = cnt;
    match_nxt   = match;
    period_nxt  = period_out;
    strobe_nxt  = 1'b0;
    timeout_nxt = timeout_out;
    if (trig_edge)                        cnt_nxt = CNT_W'(1);
    else if (state != IDLE && cnt != TMO) cnt_nxt = cnt + 1'b1;
    if (timed_out) begin
      match_nxt   = '0;
      timeout_nxt = 1'b1;
    end else if (trig_edge) begin
      case (state)
        IDLE:   timeout_nxt = 1'b0;
        ARMED:  begin
          period_nxt = cnt;
          strobe_nxt = 1'b1;
          match_nxt  = MATCH_W'(1);
        end
        TRACK:  begin
          period_nxt = cnt;
          strobe_nxt = 1'b1;
          match_nxt  = match_inc;
        end
        LOCKED: begin
          period_nxt = cnt;
          strobe_nxt = 1'b1;
          match_nxt  = same ? match : MATCH_W'(1);
        end
      endcase
    end
  end

endmodule
